// File: rtl/ex_mopa_unit.sv
// ex_mopa_unit: 4x4 signed-int8 outer-product-accumulate, one tile row written per cycle.
// Build option MOPA_SAT_EN: clamp each lane to the signed LANE_W range instead of wrapping.
module ex_mopa_unit #(
    parameter int LANE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_matrix_write_mopa,
    input  logic [1:0]          ex_matrix_index,
    input  logic [4*LANE_W-1:0] ex_regs_data1,
    input  logic [4*LANE_W-1:0] ex_regs_data2,
    input  logic [4*LANE_W-1:0] ex_M [3:0],
    input  logic                mopa_kill,
    output logic                mopa_stall,
    output logic                mopa_busy,
    output logic                mopa_wr_en,
    output logic [1:0]          mopa_wr_index,
    output logic [1:0]          mopa_wr_row,
    output logic [4*LANE_W-1:0] mopa_wr_data,
    output logic                mopa_done,
    output logic                mopa_dbg_state
);
    localparam int ROW_W = 4 * LANE_W;

    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       idx_q, idx_d;
    logic [ROW_W-1:0] a_q, a_d, b_q, b_d;
    logic [ROW_W-1:0] m_q [3:0];
    logic [ROW_W-1:0] m_d [3:0];
    logic             wr_q, done_q;
    logic [1:0]       wr_row_q, wr_idx_q;
    logic [ROW_W-1:0] data_q, data_d;
    logic             abort, start, calc_d;

    function automatic logic [LANE_W-1:0] mac_lane(input logic signed [LANE_W-1:0] m,
                                                   input logic signed [LANE_W-1:0] a,
                                                   input logic signed [LANE_W-1:0] b);
`ifdef MOPA_SAT_EN
        logic signed [2*LANE_W-1:0] p;
        logic signed [2*LANE_W:0]   s;
        p = a * b;
        s = {{(LANE_W+1){m[LANE_W-1]}}, m} + {p[2*LANE_W-1], p};
        if (s > $signed({{(LANE_W+2){1'b0}}, {(LANE_W-1){1'b1}}}))
            mac_lane = {1'b0, {(LANE_W-1){1'b1}}};
        else if (s < $signed({{(LANE_W+2){1'b1}}, {(LANE_W-1){1'b0}}}))
            mac_lane = {1'b1, {(LANE_W-1){1'b0}}};
        else
            mac_lane = s[LANE_W-1:0];
`else
        logic [LANE_W-1:0] p_lo;
        p_lo     = a * b;
        mac_lane = m + p_lo;
`endif
    endfunction

    // Stall handshake: mopa_stall high means ID/EX must hold; it drops in the row-3 cycle
    // (or on kill/reset) so the next instruction loads at that cycle's closing edge.
    assign abort = mopa_kill || rst;
    assign start = (state_q == IDLE) && ex_matrix_write_mopa && !abort;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    row_d   = 2'd0;
                    idx_d   = ex_matrix_index;
                    a_d     = ex_regs_data1;
                    b_d     = ex_regs_data2;
                    m_d     = ex_M;
                end
            end
            CALC: begin
                if (abort || row_q == 2'd3) begin
                    state_d = IDLE;
                    row_d   = 2'd0;
                end else begin
                    row_d = row_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output row is computed one edge ahead so every write output comes straight from a flop.
    always_comb begin
        calc_d = (state_d == CALC);
        data_d = '0;
        if (calc_d) begin
            for (int c = 0; c < 4; c++) begin
                data_d[c*LANE_W +: LANE_W] = mac_lane(m_d[row_d][c*LANE_W +: LANE_W],
                                                      a_d[row_d*LANE_W +: LANE_W],
                                                      b_d[c*LANE_W +: LANE_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= 2'd0;
            idx_q    <= 2'd0;
            a_q      <= '0;
            b_q      <= '0;
            for (int r = 0; r < 4; r++) m_q[r] <= '0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
            wr_row_q <= 2'd0;
            wr_idx_q <= 2'd0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            wr_q     <= calc_d;
            done_q   <= calc_d && (row_d == 2'd3);
            wr_row_q <= calc_d ? row_d : 2'd0;
            wr_idx_q <= calc_d ? idx_d : 2'd0;
            data_q   <= data_d;
        end
    end

    // A kill or reset cancels the pending write/done strobe in the same cycle.
    assign mopa_stall     = start || ((state_q == CALC) && (row_q != 2'd3) && !abort);
    assign mopa_busy      = (state_q == CALC);
    assign mopa_wr_en     = wr_q && !abort;
    assign mopa_done      = done_q && !abort;
    assign mopa_wr_index  = wr_idx_q;
    assign mopa_wr_row    = wr_row_q;
    assign mopa_wr_data   = data_q;
    assign mopa_dbg_state = state_q;

endmodule

// File: tb/tb_ex_mopa_unit.sv
// tb_ex_mopa_unit: directed self-checking bench for ex_mopa_unit with a write scoreboard.
// Expected lanes follow MOPA_SAT_EN the same way the design build does.
module tb_ex_mopa_unit;
    localparam int LANE_W = 8;
    localparam int ROW_W  = 4 * LANE_W;
    localparam int EW     = 2 + 2 + ROW_W + 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex_matrix_write_mopa;
    logic [1:0]       ex_matrix_index;
    logic [ROW_W-1:0] ex_regs_data1, ex_regs_data2;
    logic [ROW_W-1:0] ex_M [3:0];
    logic             mopa_kill;
    logic             mopa_stall, mopa_busy, mopa_wr_en, mopa_done, mopa_dbg_state;
    logic [1:0]       mopa_wr_index, mopa_wr_row;
    logic [ROW_W-1:0] mopa_wr_data;

    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    exp_e;
    logic [15:0]      cyc = 16'd0;
    int               n_cmp = 0;
    int               n_err = 0;

    ex_mopa_unit #(.LANE_W(LANE_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_matrix_write_mopa (ex_matrix_write_mopa),
        .ex_matrix_index      (ex_matrix_index),
        .ex_regs_data1        (ex_regs_data1),
        .ex_regs_data2        (ex_regs_data2),
        .ex_M                 (ex_M),
        .mopa_kill            (mopa_kill),
        .mopa_stall           (mopa_stall),
        .mopa_busy            (mopa_busy),
        .mopa_wr_en           (mopa_wr_en),
        .mopa_wr_index        (mopa_wr_index),
        .mopa_wr_row          (mopa_wr_row),
        .mopa_wr_data         (mopa_wr_data),
        .mopa_done            (mopa_done),
        .mopa_dbg_state       (mopa_dbg_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic in plain integers
    function automatic logic [7:0] lane_ref(input logic [7:0] m, input logic [7:0] a,
                                            input logic [7:0] b);
        int s;
        s = int'($signed(m)) + int'($signed(a)) * int'($signed(b));
`ifdef MOPA_SAT_EN
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
`endif
        return s[7:0];
    endfunction

    function automatic logic [31:0] row_ref(input logic [31:0] m_row, input logic [7:0] a_lane,
                                            input logic [31:0] b);
        logic [31:0] r;
        for (int c = 0; c < 4; c++) r[8*c +: 8] = lane_ref(m_row[8*c +: 8], a_lane, b[8*c +: 8]);
        return r;
    endfunction

    // Scoreboard: every write strobe must match the next expected {index,row,data,cycle}
    always @(negedge clk) begin
        if (mopa_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", mopa_wr_en, 1'b0);
            end else begin
                exp_e = exp_q.pop_front();
                check("row_write", {mopa_wr_index, mopa_wr_row, mopa_wr_data, cyc}, exp_e);
            end
        end
    end

    // Driver: issue one MOPA at the current cycle T; abort_k (1..4) kills or resets in T+k
    task automatic run_mopa(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] m0, input logic [31:0] m1, input logic [31:0] m2,
                            input logic [31:0] m3, input int abort_k, input bit use_rst);
        logic [31:0] m [4];
        int t0;
        int last;
        m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
        t0 = int'(cyc);
        ex_matrix_write_mopa = 1'b1;
        ex_matrix_index      = idx;
        ex_regs_data1        = a;
        ex_regs_data2        = b;
        for (int r = 0; r < 4; r++) ex_M[r] = m[r];
        last = (abort_k == 0) ? 3 : abort_k - 2;
        for (int r = 0; r <= last; r++)
            exp_q.push_back({idx, 2'(r), row_ref(m[r], a[8*r +: 8], b), 16'(t0 + 1 + r)});
        @(negedge clk);
        check("start_stall", mopa_stall, 1'b1);
        check("start_busy", mopa_busy, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            ex_regs_data1 = $urandom;
            ex_regs_data2 = $urandom;
            ex_M[k-1]     = $urandom;
            if (k == abort_k) begin
                if (use_rst) rst = 1'b1;
                else mopa_kill = 1'b1;
            end
            @(negedge clk);
            check("calc_busy", mopa_busy, 1'b1);
            check("calc_stall", mopa_stall, (k < 4) && (k != abort_k));
            check("calc_done", mopa_done, (k == 4) && (abort_k == 0));
            if (k == abort_k) begin
                check("abort_wr_en", mopa_wr_en, 1'b0);
                @(posedge clk); #1;
                rst = 1'b0;
                mopa_kill = 1'b0;
                ex_matrix_write_mopa = 1'b0;
                @(negedge clk);
                check("abort_busy", mopa_busy, 1'b0);
                check("abort_stall", mopa_stall, 1'b0);
                check("abort_wr_en_after", mopa_wr_en, 1'b0);
                check("abort_done", mopa_done, 1'b0);
                if (use_rst)
                    check("rst_outputs", {mopa_wr_index, mopa_wr_row, mopa_wr_data}, '0);
                @(posedge clk); #1;
                return;
            end
        end
        @(posedge clk); #1;
        ex_matrix_write_mopa = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ex_matrix_write_mopa = 1'b0;
        mopa_kill = 1'b0;
        ex_matrix_index = 2'd0;
        ex_regs_data1 = '0;
        ex_regs_data2 = '0;
        for (int r = 0; r < 4; r++) ex_M[r] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_wr_en", mopa_wr_en, 1'b0);
        check("rst_busy", mopa_busy, 1'b0);
        check("rst_done", mopa_done, 1'b0);
        check("rst_stall", mopa_stall, 1'b0);
        check("rst_bus", {mopa_wr_index, mopa_wr_row, mopa_wr_data}, '0);
        check("rst_state", mopa_dbg_state, 1'b0);

        // Non-MOPA instruction: no stall, unit stays idle
        @(posedge clk); #1;
        ex_regs_data1 = $urandom;
        ex_regs_data2 = $urandom;
        ex_matrix_index = 2'($urandom_range(0, 3));
        @(negedge clk);
        check("nonmopa_stall", mopa_stall, 1'b0);
        @(posedge clk); #1;

        // Kill in IDLE blocks the start
        ex_matrix_write_mopa = 1'b1;
        mopa_kill = 1'b1;
        @(negedge clk);
        check("idle_kill_stall", mopa_stall, 1'b0);
        @(posedge clk); #1;
        ex_matrix_write_mopa = 1'b0;
        mopa_kill = 1'b0;
        @(negedge clk);
        check("idle_kill_busy", mopa_busy, 1'b0);
        @(posedge clk); #1;

        // Basic
        run_mopa(2'd0, 32'h04030201, 32'h01010101, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        // Positive and negative overflow
        run_mopa(2'd3, 32'h00000001, 32'h01010101, 32'h7F7F7F7F, $urandom, $urandom, $urandom,
                 0, 1'b0);
        run_mopa(2'd1, 32'h000000FF, 32'h01010101, 32'h80808080, $urandom, $urandom, $urandom,
                 0, 1'b0);
        // Kills in T+3, T+4 (row-3 cycle) and T+1
        run_mopa(2'd0, 32'h04030201, 32'h01010101, 32'h0, 32'h0, 32'h0, 32'h0, 3, 1'b0);
        run_mopa(2'd2, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 4, 1'b0);
        run_mopa(2'd1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1, 1'b0);
        // Back-to-back, index 1 then index 2
        run_mopa(2'd1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 0, 1'b0);
        run_mopa(2'd2, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 0, 1'b0);
        // Reset in T+2, then Basic again
        run_mopa(2'd3, 32'h04030201, 32'h01010101, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1);
        run_mopa(2'd0, 32'h04030201, 32'h01010101, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        // Random tiles
        for (int i = 0; i < 4; i++)
            run_mopa(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, 0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
